hlsm_accum_seq: RTL and testbench

Parametrised accumulate-loop engine: on `start` it computes the sum of `f(i)` for `i = 0 … n-1`, where `f(i) = i` (mode 0) or `f(i) = i*i` (mode 1). It returns a WIDTH-bit result with a one-cycle `done` pulse and a sticky overflow flag. The block is the next-generation replacement for the fixed 4-bit sum loop. It keeps the controller/datapath split and the alternating check/accumulate loop, and adds width parameterisation, a mode select, busy/done handshake and overflow handling.

---
 rtl/hlsm_pkg.sv | 24 ++
 rtl/hlsm_accum_dp.sv | 104 ++++++++++
 rtl/hlsm_accum_seq.sv | 107 ++++++++++
 tb/tb_hlsm_accum_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hlsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hlsm_pkg
// Purpose  : Shared definitions for the hlsm_accum_seq accumulate-loop engine.
//            Holds the controller state encoding and the mode constants.
// Contents : hlsm_state_t  - 2-bit controller state
//            HLSM_MODE_SUM - mode value selecting f(i) = i
//            HLSM_MODE_SQ  - mode value selecting f(i) = i*i
// Revision : 1.0 - initial release
// ============================================================================
package hlsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b10,
    ACC   = 2'b01,
    DONE  = 2'b11
  } hlsm_state_t;

  localparam logic HLSM_MODE_SUM = 1'b0;
  localparam logic HLSM_MODE_SQ  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/hlsm_accum_dp.sv
`default_nettype none
// ============================================================================
// Module   : hlsm_accum_dp
// Purpose  : Datapath for hlsm_accum_seq: loop index, accumulator, captured
//            bound/mode, run-overflow tracking and the result registers.
// Ports    : clk, rst (async active-low)
//            clr     - clear index and accumulator (controller in IDLE)
//            cap     - capture n/mode, clear run-overflow (start accepted)
//            i_ld    - increment loop index
//            sum_ld  - accumulate f(i) into sum
//            res_ld  - publish sum and run-overflow to result/ovf
//            n, mode - run parameters (sampled only on cap)
//            i_lt_n  - comparator output i < n_q
//            result, ovf - last completed run
// Config   : HLSM_ACCUM_SAT_EN - saturate accumulator on overflow
// Revision : 1.0 - initial release
// ============================================================================
module hlsm_accum_dp
  import hlsm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cap,
  input  logic             i_ld,
  input  logic             sum_ld,
  input  logic             res_ld,
  input  logic [WIDTH-1:0] n,
  input  logic             mode,
  output logic             i_lt_n,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  logic [WIDTH-1:0]   i_q;
  logic [WIDTH-1:0]   sum_q;
  logic [WIDTH-1:0]   n_q;
  logic               mode_q;
  logic               run_ovf_q;

  logic [2*WIDTH-1:0] i_ext;
  logic [2*WIDTH-1:0] prod;
  logic               prod_ovf;
  logic [WIDTH-1:0]   f_val;
  logic [WIDTH:0]     add;
  logic               step_ovf;
  logic [WIDTH-1:0]   sum_nxt;

  always_comb begin
    i_ext    = {{WIDTH{1'b0}}, i_q};
    prod     = i_ext * i_ext;
    // Upper half of the square only matters when squares are being summed.
    prod_ovf = (mode_q == HLSM_MODE_SQ) && (|prod[2*WIDTH-1:WIDTH]);
    f_val    = (mode_q == HLSM_MODE_SUM) ? i_q : prod[WIDTH-1:0];
`ifdef HLSM_ACCUM_SAT_EN
    if (prod_ovf) f_val = {WIDTH{1'b1}};
`endif
    add      = {1'b0, sum_q} + {1'b0, f_val};
    step_ovf = prod_ovf | add[WIDTH];
`ifdef HLSM_ACCUM_SAT_EN
    // Once the run has overflowed the accumulator stays pinned at all-ones.
    sum_nxt  = (run_ovf_q | step_ovf) ? {WIDTH{1'b1}} : add[WIDTH-1:0];
`else
    sum_nxt  = add[WIDTH-1:0];
`endif
    i_lt_n   = (i_q < n_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q       <= '0;
      sum_q     <= '0;
      n_q       <= '0;
      mode_q    <= 1'b0;
      run_ovf_q <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
    end else begin
      if (clr) begin
        i_q   <= '0;
        sum_q <= '0;
      end
      if (cap) begin
        n_q       <= n;
        mode_q    <= mode;
        run_ovf_q <= 1'b0;
      end
      // i never passes n_q, so the increment cannot wrap.
      if (i_ld)   i_q <= i_q + WIDTH'(1);
      if (sum_ld) begin
        sum_q     <= sum_nxt;
        run_ovf_q <= run_ovf_q | step_ovf;
      end
      if (res_ld) begin
        result <= sum_q;
        ovf    <= run_ovf_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hlsm_accum_seq.sv
`default_nettype none
// ============================================================================
// Module   : hlsm_accum_seq
// Purpose  : Accumulate-loop engine. On start computes sum of f(i) for
//            i = 0..n-1 with f(i) = i (mode 0) or i*i (mode 1), reports the
//            WIDTH-bit result with a one-cycle done pulse and an overflow flag.
// Ports    : clk    - rising-edge clock
//            rst    - asynchronous active-low reset
//            start  - run request, sampled in IDLE only
//            n      - loop bound (captured on accept)
//            mode   - 0 sum of i, 1 sum of i^2 (captured on accept)
//            busy   - high whenever not IDLE
//            done   - one-cycle completion pulse
//            result - last completed sum
//            ovf    - last run exceeded WIDTH bits
// Config   : HLSM_ACCUM_SAT_EN - saturate accumulator on overflow
// Revision : 1.0 - initial release
// ============================================================================
module hlsm_accum_seq
  import hlsm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  hlsm_state_t state;
  hlsm_state_t state_nxt;

  logic clr;
  logic cap;
  logic i_ld;
  logic sum_ld;
  logic res_ld;
  logic i_lt_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    cap       = 1'b0;
    i_ld      = 1'b0;
    sum_ld    = 1'b0;
    res_ld    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        clr  = 1'b1;
        if (start) begin
          cap       = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (i_lt_n) begin
          state_nxt = ACC;
        end else begin
          res_ld    = 1'b1;
          state_nxt = DONE;
        end
      end
      ACC: begin
        i_ld      = 1'b1;
        sum_ld    = 1'b1;
        state_nxt = CHECK;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  hlsm_accum_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .cap    (cap),
    .i_ld   (i_ld),
    .sum_ld (sum_ld),
    .res_ld (res_ld),
    .n      (n),
    .mode   (mode),
    .i_lt_n (i_lt_n),
    .result (result),
    .ovf    (ovf)
  );

endmodule
`default_nettype wire

// File: tb/tb_hlsm_accum_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_hlsm_accum_seq
// Purpose  : Self-checking bench for hlsm_accum_seq (WIDTH = 8). Honours
//            HLSM_ACCUM_SAT_EN when choosing expected results.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hlsm_accum_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] n = '0;
  logic         mode = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;

  int checks = 0;
  int failures = 0;

  hlsm_accum_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .n      (n),
    .mode   (mode),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] n;
    logic         mode;
    logic [W-1:0] res_wrap;
    logic [W-1:0] res_sat;
    logic         ovf;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic over the whole run, then wrap or clamp.
  function automatic void model(input int nv, input bit mv,
                                output logic [W-1:0] res, output logic ov);
    longint total = 0;
    for (int k = 0; k < nv; k++) begin
      total += mv ? longint'(k) * longint'(k) : longint'(k);
    end
    ov = (total >= (64'd1 << W));
`ifdef HLSM_ACCUM_SAT_EN
    res = ov ? {W{1'b1}} : W'(total);
`else
    res = W'(total);
`endif
  endfunction

  // Starts a run from IDLE (called at #1 after an edge) and waits for done.
  // jitter scrambles n/mode/start while busy; pulse_at injects a start with
  // n=2 that many cycles after acceptance.
  task automatic run(input logic [W-1:0] nv, input logic mv, input bit jitter,
                     input int pulse_at, output int lat, output logic [W-1:0] res,
                     output logic ov, output bit busy_ok, output bit to);
    start = 1'b1; n = nv; mode = mv;
    @(posedge clk); #1;
    start = 1'b0; lat = 0; to = 1'b0; busy_ok = 1'b1;
    while (done !== 1'b1) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (jitter) begin
        n = W'($urandom); mode = 1'($urandom); start = 1'($urandom);
      end else if (lat == pulse_at) begin
        start = 1'b1; n = 8'd2;
      end else begin
        start = 1'b0;
      end
      if (lat > 1000) begin to = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    res = result; ov = ovf;
    if (busy !== 1'b1) busy_ok = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    if (busy !== 1'b0 || done !== 1'b0) busy_ok = 1'b0;
  endtask

  initial begin
    vec_t         vecs [6];
    int           lat;
    logic [W-1:0] res;
    logic         ov;
    bit           bok;
    bit           to;
    logic [W-1:0] exp_res;
    logic         exp_ov;
    int           pulse_t [4];
    int           np;
    int           cyc;

    vecs[0] = '{n: 8'd5,  mode: 1'b0, res_wrap: 8'd10,  res_sat: 8'd10,  ovf: 1'b0, lat: 11};
    vecs[1] = '{n: 8'd4,  mode: 1'b1, res_wrap: 8'd14,  res_sat: 8'd14,  ovf: 1'b0, lat: 9};
    vecs[2] = '{n: 8'd10, mode: 1'b1, res_wrap: 8'd29,  res_sat: 8'd255, ovf: 1'b1, lat: 21};
    vecs[3] = '{n: 8'd0,  mode: 1'b0, res_wrap: 8'd0,   res_sat: 8'd0,   ovf: 1'b0, lat: 1};
    vecs[4] = '{n: 8'd23, mode: 1'b0, res_wrap: 8'd253, res_sat: 8'd253, ovf: 1'b0, lat: 47};
    vecs[5] = '{n: 8'd24, mode: 1'b0, res_wrap: 8'd20,  res_sat: 8'd255, ovf: 1'b1, lat: 49};

    // Reset state
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int v = 0; v < 6; v++) begin
      run(vecs[v].n, vecs[v].mode, 1'b0, -1, lat, res, ov, bok, to);
      chk($sformatf("tbl%0d_timeout", v), to, 0);
`ifdef HLSM_ACCUM_SAT_EN
      chk($sformatf("tbl%0d_result", v), res, vecs[v].res_sat);
`else
      chk($sformatf("tbl%0d_result", v), res, vecs[v].res_wrap);
`endif
      chk($sformatf("tbl%0d_ovf", v), ov, vecs[v].ovf);
      chk($sformatf("tbl%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("tbl%0d_busy", v), bok, 1);
    end

    // start while busy is ignored
    run(8'd5, 1'b0, 1'b0, 4, lat, res, ov, bok, to);
    chk("ignore_result", res, 10);
    chk("ignore_latency", lat, 11);
    chk("ignore_busy", bok, 1);

    // Asynchronous reset mid-run
    start = 1'b1; n = 8'd5; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run(8'd3, 1'b0, 1'b0, -1, lat, res, ov, bok, to);
    chk("after_rst_result", res, 3);
    chk("after_rst_latency", lat, 7);

    // start held high: back-to-back runs
    start = 1'b1; n = 8'd2; mode = 1'b0;
    np = 0; cyc = 0;
    while (np < 4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) begin
        pulse_t[np] = cyc;
        np++;
        chk($sformatf("held_result%0d", np), result, 1);
      end
    end
    start = 1'b0;
    chk("held_pulses", np, 4);
    for (int p = 1; p < np; p++)
      chk($sformatf("held_interval%0d", p), pulse_t[p] - pulse_t[p-1], 7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    while (busy === 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end

    // Randomised runs with scrambled inputs while busy
    for (int r = 0; r < 40; r++) begin
      logic [W-1:0] rn;
      logic         rm;
      rn = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 30));
      rm = 1'($urandom);
      model(int'(rn), rm, exp_res, exp_ov);
      run(rn, rm, 1'b1, -1, lat, res, ov, bok, to);
      chk($sformatf("rnd%0d_n%0d_m%0d_result", r, rn, rm), res, exp_res);
      chk($sformatf("rnd%0d_ovf", r), ov, exp_ov);
      chk($sformatf("rnd%0d_latency", r), lat, 2 * int'(rn) + 1);
      chk($sformatf("rnd%0d_busy", r), bok, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
